// File: rtl/lcd_capture.sv
// lcd_capture: turns VSYNC/DE-framed 1-bit video back into framebuffer write
// cycles and checks every frame against the WIDTH x HEIGHT geometry.
module lcd_capture #(
    parameter int WIDTH  = 480,
    parameter int HEIGHT = 272,
    parameter int ADDR_W = 17
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ce,
    input  logic              i_vsync,
    input  logic              i_hsync,
    input  logic              i_de,
    input  logic              i_pixel,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_dout,
    output logic              o_write,
    output logic              o_frame_done,
    output logic              o_locked,
    output logic              o_err,
    output logic [8:0]        o_width,
    output logic [8:0]        o_height,
    output logic              o_dbg_active,
    output logic              o_dbg_hsync
);

    localparam logic [8:0]      WIDTH_C  = 9'(WIDTH);
    localparam logic [8:0]      HEIGHT_C = 9'(HEIGHT);
    localparam logic [8:0]      CNT_MAX  = 9'd511;
    localparam logic [ADDR_W:0] LB_STEP  = (ADDR_W+1)'(WIDTH);
    localparam logic [ADDR_W:0] ADDR_MAX = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic {
        WAIT_VS = 1'b0,
        ACTIVE  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                vsync_q, de_q, hsync_q;
    logic [8:0]          x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0]   lb_q, lb_d;
    logic                bad_q, bad_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                dout_q, dout_d;
    logic                write_q, write_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                locked_q, locked_d;
    logic [8:0]          width_q, width_d;
    logic [8:0]          height_q, height_d;
    logic [ADDR_W:0]     lb_sum;
    logic                fs, le;

    assign fs     = vsync_q & ~i_vsync;
    assign le     = de_q & ~i_de;
    assign lb_sum = {1'b0, lb_q} + LB_STEP;

    // Events on one sample resolve in order: line end (old line), frame
    // start, then the DE pixel, which lands at (0,0) of the new frame.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        lb_d     = lb_q;
        bad_d    = bad_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        write_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        locked_d = locked_q;
        width_d  = width_q;
        height_d = height_q;
        if (i_ce) begin
            if (state_q == ACTIVE && le) begin
                width_d = x_q;
                if (x_q != WIDTH_C) begin
                    err_d    = 1'b1;
                    bad_d    = 1'b1;
                    locked_d = 1'b0;
                end
                x_d  = 9'd0;
                if (y_q != CNT_MAX) y_d = y_q + 9'd1;
                lb_d = (lb_sum > ADDR_MAX) ? ADDR_MAX[ADDR_W-1:0] : lb_sum[ADDR_W-1:0];
            end
            if (fs) begin
                if (state_q == ACTIVE) begin
                    height_d = y_d;
                    if (y_d != HEIGHT_C) begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                    end else if (!bad_d) begin
                        done_d   = 1'b1;
                        locked_d = 1'b1;
                    end
                end
                state_d = ACTIVE;
                x_d     = 9'd0;
                y_d     = 9'd0;
                lb_d    = '0;
                bad_d   = 1'b0;
            end
            if (state_d == ACTIVE && i_de) begin
                if (x_d < WIDTH_C && y_d < HEIGHT_C) begin
                    write_d = 1'b1;
                    addr_d  = lb_d + ADDR_W'(x_d);
                    dout_d  = i_pixel;
                end
                if (x_d != CNT_MAX) x_d = x_d + 9'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= WAIT_VS;
            vsync_q  <= 1'b0;
            de_q     <= 1'b0;
            hsync_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            lb_q     <= '0;
            bad_q    <= 1'b0;
            addr_q   <= '0;
            dout_q   <= 1'b0;
            write_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            width_q  <= '0;
            height_q <= '0;
        end else begin
            if (i_ce) begin
                vsync_q <= i_vsync;
                de_q    <= i_de;
                hsync_q <= i_hsync;
            end
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            lb_q     <= lb_d;
            bad_q    <= bad_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            write_q  <= write_d;
            done_q   <= done_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            width_q  <= width_d;
            height_q <= height_d;
        end
    end

    // o_write is a one-cycle strobe with no ready: the framebuffer must take every write.
    assign o_addr       = addr_q;
    assign o_dout       = dout_q;
    assign o_write      = write_q;
    assign o_frame_done = done_q;
    assign o_err        = err_q;
    assign o_locked     = locked_q;
    assign o_width      = width_q;
    assign o_height     = height_q;
    assign o_dbg_active = (state_q == ACTIVE);
    assign o_dbg_hsync  = hsync_q;

endmodule

// File: tb/tb_lcd_capture.sv
// Directed bench for lcd_capture on a reduced 16x8 geometry with a 7-bit
// address so frame-level behaviour and address saturation fit in a short run.
module tb_lcd_capture;
    localparam int W  = 16;
    localparam int H  = 8;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b0;
    logic          vs = 1'b1;
    logic          hs = 1'b1;
    logic          de = 1'b0;
    logic          px = 1'b0;
    logic [AW-1:0] o_addr;
    logic          o_dout, o_write, o_frame_done, o_locked, o_err;
    logic [8:0]    o_width, o_height;
    logic          o_dbg_active, o_dbg_hsync;

    int n_cmp = 0;
    int n_err = 0;
    int gap = 4;
    int wr_cnt = 0;
    int max_addr = 0;
    logic [AW:0] exp_q[$];

    lcd_capture #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_vsync(vs), .i_hsync(hs),
        .i_de(de), .i_pixel(px), .o_addr(o_addr), .o_dout(o_dout),
        .o_write(o_write), .o_frame_done(o_frame_done), .o_locked(o_locked),
        .o_err(o_err), .o_width(o_width), .o_height(o_height),
        .o_dbg_active(o_dbg_active), .o_dbg_hsync(o_dbg_hsync)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One video sample: drive, strobe i_ce, check the n+1 outputs, then idle gap cycles.
    task automatic step(input logic v, input logic d, input logic p, input logic ew,
                        input int ea, input logic ee, input logic efd);
        vs = v; de = d; px = p;
        hs = 1'($urandom_range(0, 1));
        ce = 1'b1;
        if (ew) exp_q.push_back({p, AW'(ea)});
        @(posedge clk); #1;
        ce = 1'b0;
        chk("write strobe", o_write, ew);
        if (o_write === 1'b1) begin
            wr_cnt++;
            if (int'(o_addr) > max_addr) max_addr = int'(o_addr);
        end
        if (ew) chk("write dout/addr", {o_dout, o_addr}, exp_q.pop_front());
        chk("err pulse", o_err, ee);
        chk("frame_done pulse", o_frame_done, efd);
        chk("hsync sample", o_dbg_hsync, hs);
        repeat (gap) begin
            @(posedge clk); #1;
            chk("write idle", o_write, 1'b0);
            chk("err one cycle", o_err, 1'b0);
            chk("frame_done one cycle", o_frame_done, 1'b0);
        end
    endtask

    task automatic send_line(input int y, input int npix, input int xs, input logic v_end,
                             input logic ee, input logic efd);
        for (int x = xs; x < npix; x++)
            step(1'b1, 1'b1, ((x ^ y) & 1) != 0, (x < W) && (y < H), y * W + x, 1'b0, 1'b0);
        step(v_end, 1'b0, 1'b0, 1'b0, 0, ee, efd);
        chk("o_width", o_width, 32'(npix));
        if (ee) chk("o_locked cleared", o_locked, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int nlines, input int npix, input int bad_line, input int bad_npix);
        int n;
        for (int y = 0; y < nlines; y++) begin
            n = (y == bad_line) ? bad_npix : npix;
            send_line(y, n, 0, 1'b1, n != W, 1'b0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " o_addr"}, o_addr, 0);
        chk({tag, " o_dout"}, o_dout, 0);
        chk({tag, " o_write"}, o_write, 0);
        chk({tag, " o_frame_done"}, o_frame_done, 0);
        chk({tag, " o_locked"}, o_locked, 0);
        chk({tag, " o_err"}, o_err, 0);
        chk({tag, " o_width"}, o_width, 0);
        chk({tag, " o_height"}, o_height, 0);
        chk({tag, " state"}, o_dbg_active, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // DE activity before any vsync fall must not write
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("pre-vsync writes", wr_cnt, 0);
        chk("pre-vsync state", o_dbg_active, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("armed state", o_dbg_active, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Nominal frame
        wr_cnt = 0; max_addr = 0;
        send_frame(H, W, -1, 0);
        chk("frame A writes", wr_cnt, 128);
        chk("frame A max addr", max_addr, 127);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        chk("frame A locked", o_locked, 1'b1);
        chk("frame A height", o_height, 8);
        chk("frame A width", o_width, 16);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Short line 5: error at its DE fall, no frame_done
        send_frame(H, W, 5, 15);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("frame B height", o_height, 8);
        chk("frame B locked", o_locked, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Clean frame relocks
        send_frame(H, W, -1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        chk("frame C locked", o_locked, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Overlong frame: 10 lines of 17; closed by vsync fall together with a DE pixel
        wr_cnt = 0; max_addr = 0;
        send_frame(10, 17, -1, 0);
        chk("frame D writes", wr_cnt, 128);
        chk("frame D max addr", max_addr, 127);
        step(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0);
        chk("frame D height", o_height, 10);
        chk("frame D locked", o_locked, 1'b0);

        // Frame E continues from (1,0); last DE fall coincides with vsync fall
        send_line(0, W, 1, 1'b1, 1'b0, 1'b0);
        for (int y = 1; y < H - 1; y++) send_line(y, W, 0, 1'b1, 1'b0, 1'b0);
        send_line(H - 1, W, 0, 1'b0, 1'b0, 1'b1);
        chk("frame E height", o_height, 8);
        chk("frame E locked", o_locked, 1'b1);

        // Back-to-back i_ce
        gap = 0;
        wr_cnt = 0;
        send_frame(H, W, -1, 0);
        chk("frame F writes", wr_cnt, 128);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("frame F locked", o_locked, 1'b1);
        gap = 4;

        // Reset mid-frame
        for (int x = 0; x < 3; x++) step(1'b1, 1'b1, (x & 1) != 0, 1'b1, x, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("mid-frame reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wr_cnt = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("post-reset writes", wr_cnt, 0);
        chk("post-reset locked", o_locked, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        send_line(0, W, 0, 1'b1, 1'b0, 1'b0);
        chk("post-reset line writes", wr_cnt, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lcd_capture.md
# lcd_capture

Video capture receiver: the receiving end of the LCD RGB timing interface. It decodes VSYNC/HSYNC/DE and a 1-bit pixel stream back into framebuffer write cycles (address, data, write strobe), checks the incoming frame geometry, and reports lock and errors. It sits between an LCD-style video source and framebuffer port A. Typical uses are loading a seed pattern from an external video source, and loopback-checking the display timing generator.

## Interface
- WIDTH, 480: active pixels per line.
- HEIGHT, 272: active lines per frame.
- ADDR_W, 17: framebuffer address width.
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_ce  in  1  pixel strobe. Video inputs are sampled only on cycles where i_ce=1.
- i_vsync  in  1  vertical sync, active-low.
- i_hsync  in  1  horizontal sync, active-low. Monitored only; see Operation.
- i_de  in  1  data enable, active-high.
- i_pixel  in  1  cell state for the current pixel.
- o_addr  out  ADDR_W  framebuffer write address.
- o_dout  out  1  framebuffer write data.
- o_write  out  1  write strobe, one i_clk cycle per captured pixel.
- o_frame_done  out  1  one-cycle pulse when a geometrically correct frame completes.
- o_locked  out  1  set after one good frame; cleared on any error.
- o_err  out  1  one-cycle pulse on a geometry error.
- o_width  out  9  last measured line length.
- o_height  out  9  last measured frame height.

## Operation
- **Sampling.** On i_ce=1, register vsync_q and de_q (previous samples). Edges are computed as current vs. previous sample.
  - Frame start (fs): vsync 1→0.
  - Line end (le): de 1→0.
- **State machine:** WAIT_VS, ACTIVE.
  - WAIT_VS: no writes. fs → ACTIVE, with x=0, y=0, line_base=0, frame_bad=0.
  - ACTIVE, pixel: de=1 on a sample → capture the pixel at (x, y).
    - If x<WIDTH and y<HEIGHT: issue a write with o_addr=line_base+x and o_dout=i_pixel.
    - Otherwise suppress the write.
    - Then x saturates-increments (limit 511).
  - ACTIVE, le:
    - o_width←x.
    - If x≠WIDTH: o_err pulse, frame_bad=1, locked=0.
    - Then x=0, y saturates-increments (limit 511), line_base+=WIDTH (saturate at the maximum address; writes are already gated by the y check).
  - ACTIVE, fs (end of the previous frame):
    - o_height←y.
    - If y≠HEIGHT: o_err pulse, locked=0.
    - Else if frame_bad=0: o_frame_done pulse, locked=1.
    - Then reset x, y, line_base and frame_bad; stay in ACTIVE.
- **Address arithmetic.** No multiplier: line_base is an ADDR_W-bit running sum. The maximum valid address is WIDTH*HEIGHT−1 = 130559.
- **Simultaneous events** on one sample, processed in this order:
  1. le, using counts from the old line.
  2. fs.
  3. The de=1 pixel, which belongs to the new frame at (0,0).
- **Lines without DE.** A line with no DE activity is not counted. Height equals the number of DE bursts.
- **HSYNC** is not used for counting. It is sampled only so the bench can check pin connectivity.
- **Reset mid-frame.** Return to WAIT_VS immediately. No writes occur until the next fs. o_width, o_height and o_locked are all cleared.

## Timing
- **Reset values:** all outputs 0; state WAIT_VS.
- **Write latency:**
  - A pixel sampled on i_ce at cycle n produces o_write=1 in cycle n+1 only, with o_addr/o_dout valid in the same cycle.
  - o_addr/o_dout hold their values when o_write=0.
- **Status latency:** o_err, o_frame_done, o_width and o_height update in cycle n+1 after the sampling edge.
  - o_frame_done and o_err are exactly one i_clk cycle wide, regardless of i_ce rate.
- **Lock timing:** o_locked changes in the same cycle as the o_frame_done or o_err pulse.
- **Throughput:** one write per i_ce, up to i_ce=1 every cycle. No back-pressure; the framebuffer must accept every write.

## Test plan
- **Reset:** assert i_rst_n=0 mid-stream → all outputs 0 within the reset cycle. After release, DE activity before the first vsync fall → zero writes.
- **Nominal frame:** one 480×272 frame, i_ce every 5th cycle, pixel = x[0]^y[0].
  - 130560 writes.
  - First write addr 0, last write addr 130559.
  - Addr of (10,3) = 1450.
  - o_frame_done pulses once at the next vsync fall; o_locked=1; o_width=480, o_height=272.
- **Short line:** line 5 has 479 DE samples.
  - o_err pulses at that DE fall; o_width=479; o_locked→0.
  - No o_frame_done for that frame.
  - The next clean frame relocks.
- **Overlong frame:** 275 lines, 481-pixel lines.
  - Writes for x=480 and for y≥272 are suppressed, so the maximum observed addr is 130559.
  - o_err pulses at each line end and again at vsync; o_height=275.
- **Simultaneous events:** vsync fall on the same sample as DE fall and a new DE rise.
  - Line closed with the correct o_width.
  - Frame evaluated.
  - The pixel is written to addr 0.
- **Back-to-back i_ce:** i_ce held at 1 → one write per cycle with consecutive addresses; no drops or duplicates.
